// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
//
// Programmable timer controller: an 8-bit up-counter stepped by a clock
// prescaler, compared against a programmable period. It supports one-shot and
// periodic modes, start/pause/abort control and a sticky interrupt with
// acknowledge and overrun detection. All outputs are registered.
//
// Parameters
//   WIDTH         counter and period width
//   PW            prescaler width
//
// Ports
//   clk           clock, all state changes on the rising edge
//   reset         synchronous active-high reset
//   cfg_we        write strobe for cfg_period / cfg_mode / cfg_prescale
//   cfg_period    terminal value P
//   cfg_mode      0 = one-shot, 1 = periodic
//   cfg_prescale  prescale S; the counter steps once per S+1 clocks
//   start         start (from IDLE/DONE) or resume (from PAUSE)
//   stop          pause from RUN, abort from PAUSE, clear from DONE
//   irq_ack       clears irq and ovf
//   value         current count
//   running       high while in RUN
//   done          high while in DONE (one-shot finished)
//   tc            one-cycle terminal-count pulse
//   irq           sticky interrupt request
//   ovf           sticky overrun: terminal count while irq was already set
//   cfg_err       one-cycle pulse: a cfg_we arrived while RUN or PAUSE
// -----------------------------------------------------------------------------
module timer_ctrl #(
    parameter int WIDTH = 8,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic [PW-1:0]    cfg_prescale,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] value,
    output logic             running,
    output logic             done,
    output logic             tc,
    output logic             irq,
    output logic             ovf,
    output logic             cfg_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] value_q,    value_d;
    logic [PW-1:0]    pcnt_q,     pcnt_d;
    logic [WIDTH-1:0] period_q,   period_d;
    logic             mode_q,     mode_d;
    logic [PW-1:0]    prescale_q, prescale_d;
    logic             tc_q,       tc_d;
    logic             irq_q,      irq_d;
    logic             ovf_q,      ovf_d;
    logic             cfg_err_q,  cfg_err_d;
    logic             terminal;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned; otherwise a latch would be inferred.
        state_d    = state_q;
        value_d    = value_q;
        pcnt_d     = pcnt_q;
        period_d   = period_q;
        mode_d     = mode_q;
        prescale_d = prescale_q;
        tc_d       = 1'b0;
        irq_d      = irq_q;
        ovf_d      = ovf_q;
        cfg_err_d  = 1'b0;
        terminal   = 1'b0;

        // Configuration is only writable while no run is active, so a
        // running count never sees its period or prescale change.
        if (cfg_we) begin
            if (state_q == ST_IDLE || state_q == ST_DONE) begin
                period_d   = cfg_period;
                mode_d     = cfg_mode;
                prescale_d = cfg_prescale;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        // stop is tested first in every state so it always beats start.
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    value_d = '0;
                    pcnt_d  = '0;
                end else if (start) begin
                    state_d = ST_RUN;
                    value_d = '0;
                    pcnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    // Pause freezes both counters; no tick this cycle.
                    state_d = ST_PAUSE;
                end else if (pcnt_q == prescale_q) begin
                    pcnt_d = '0;
                    if (value_q == period_q) begin
                        terminal = 1'b1;
                        if (mode_q) begin
                            value_d = '0;
                        end else begin
                            // One-shot parks in DONE showing the final count.
                            state_d = ST_DONE;
                        end
                    end else begin
                        value_d = value_q + WIDTH'(1);
                    end
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    value_d = '0;
                    pcnt_d  = '0;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        // Acknowledge clears first; a terminal event in the same cycle then
        // re-asserts irq, and flags an overrun if irq was already pending.
        if (irq_ack) begin
            irq_d = 1'b0;
            ovf_d = 1'b0;
        end
        if (terminal) begin
            tc_d  = 1'b1;
            irq_d = 1'b1;
            if (irq_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge value regardless of statement order.
        if (reset) begin
            state_q    <= ST_IDLE;
            value_q    <= '0;
            pcnt_q     <= '0;
            period_q   <= '1;
            mode_q     <= 1'b0;
            prescale_q <= '0;
            tc_q       <= 1'b0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            pcnt_q     <= pcnt_d;
            period_q   <= period_d;
            mode_q     <= mode_d;
            prescale_q <= prescale_d;
            tc_q       <= tc_d;
            irq_q      <= irq_d;
            ovf_q      <= ovf_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign value   = value_q;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign tc      = tc_q;
    assign irq     = irq_q;
    assign ovf     = ovf_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
//
// Directed testbench for timer_ctrl. A behavioural model tracks how many
// active (ticking-eligible) cycles have elapsed since start and derives the
// count from elapsed/(S+1) mod (P+1); terminal events occur whenever the
// elapsed count reaches a multiple of (P+1)(S+1). A compare process checks
// every output against the model on each falling edge, and the stimulus
// process adds hand-computed literal expectations at key cycles.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

    localparam int WIDTH = 8;
    localparam int PW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_period;
    logic             cfg_mode;
    logic [PW-1:0]    cfg_prescale;
    logic             start;
    logic             stop;
    logic             irq_ack;
    logic [WIDTH-1:0] value;
    logic             running;
    logic             done;
    logic             tc;
    logic             irq;
    logic             ovf;
    logic             cfg_err;

    timer_ctrl #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_period   (cfg_period),
        .cfg_mode     (cfg_mode),
        .cfg_prescale (cfg_prescale),
        .start        (start),
        .stop         (stop),
        .irq_ack      (irq_ack),
        .value        (value),
        .running      (running),
        .done         (done),
        .tc           (tc),
        .irq          (irq),
        .ovf          (ovf),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_e;

    mstate_e m_state = M_IDLE;
    int      m_act   = 0;     // active counting cycles since the run began
    int      m_p     = 255;
    int      m_s     = 0;
    bit      m_mode  = 1'b0;
    bit      m_tc    = 1'b0;
    bit      m_irq   = 1'b0;
    bit      m_ovf   = 1'b0;
    bit      m_err   = 1'b0;
    bit      m_valid = 1'b0;
    bit      m_term;
    bit      m_irq_was;
    int      m_len;

    always @(posedge clk) begin
        if (reset) begin
            m_state = M_IDLE;
            m_act   = 0;
            m_p     = 255;
            m_s     = 0;
            m_mode  = 1'b0;
            m_tc    = 1'b0;
            m_irq   = 1'b0;
            m_ovf   = 1'b0;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_term    = 1'b0;
            m_len     = (m_p + 1) * (m_s + 1);
            m_irq_was = m_irq;
            m_err     = cfg_we && (m_state == M_RUN || m_state == M_PAUSE);
            case (m_state)
                M_IDLE, M_DONE: begin
                    if (stop) begin
                        m_state = M_IDLE;
                        m_act   = 0;
                    end else if (start) begin
                        m_state = M_RUN;
                        m_act   = 0;
                    end
                end
                M_RUN: begin
                    if (stop) begin
                        m_state = M_PAUSE;
                    end else begin
                        m_act++;
                        if (m_act % m_len == 0) begin
                            m_term = 1'b1;
                            if (!m_mode) m_state = M_DONE;
                        end
                    end
                end
                M_PAUSE: begin
                    if (stop) begin
                        m_state = M_IDLE;
                        m_act   = 0;
                    end else if (start) begin
                        m_state = M_RUN;
                    end
                end
            endcase
            if (cfg_we && !m_err) begin
                m_p    = int'(cfg_period);
                m_s    = int'(cfg_prescale);
                m_mode = cfg_mode;
            end
            m_tc = m_term;
            if (irq_ack) begin
                m_irq = 1'b0;
                m_ovf = 1'b0;
            end
            if (m_term) begin
                m_irq = 1'b1;
                if (m_irq_was) m_ovf = 1'b1;
            end
        end
    end

    function automatic int exp_value();
        case (m_state)
            M_RUN, M_PAUSE: return (m_act / (m_s + 1)) % (m_p + 1);
            M_DONE:         return m_p;
            default:        return 0;
        endcase
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_value",   32'(value),   32'(exp_value()));
            check("cmp_running", 32'(running), 32'(m_state == M_RUN));
            check("cmp_done",    32'(done),    32'(m_state == M_DONE));
            check("cmp_tc",      32'(tc),      32'(m_tc));
            check("cmp_irq",     32'(irq),     32'(m_irq));
            check("cmp_ovf",     32'(ovf),     32'(m_ovf));
            check("cmp_cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic configure(input int p, input int s, input bit mode);
        cfg_period   = WIDTH'(p);
        cfg_prescale = PW'(s);
        cfg_mode     = mode;
        cfg_we       = 1'b1;
        tick();
        cfg_we       = 1'b0;
    endtask

    // start is sampled in cycle 0; on return the bench is in cycle 1.
    task automatic start_run();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic abort_run();
        stop = 1'b1;
        tick();
        tick();
        stop = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        cfg_we       = 1'b0;
        cfg_period   = '0;
        cfg_mode     = 1'b0;
        cfg_prescale = '0;
        start        = 1'b0;
        stop         = 1'b0;
        irq_ack      = 1'b0;
        tick();
        tick();
        check("rst_value",   32'(value),   0);
        check("rst_running", 32'(running), 0);
        check("rst_irq",     32'(irq),     0);
        check("rst_tc",      32'(tc),      0);
        reset = 1'b0;
        tick();

        // Periodic count P=3, S=0
        configure(3, 0, 1'b1);
        start_run();
        check("per_c1_value",   32'(value),   0);
        check("per_c1_running", 32'(running), 1);
        wait_to(4);
        check("per_c4_value", 32'(value), 3);
        wait_to(5);
        check("per_c5_tc",    32'(tc),    1);
        check("per_c5_irq",   32'(irq),   1);
        check("per_c5_value", 32'(value), 0);
        wait_to(6);
        check("per_c6_tc", 32'(tc), 0);
        wait_to(9);
        check("per_c9_tc",  32'(tc),  1);
        check("per_c9_ovf", 32'(ovf), 1);
        wait_to(13);
        check("per_c13_tc", 32'(tc), 1);
        abort_run();
        check("per_abort_running", 32'(running), 0);
        ack();
        check("per_ack_irq", 32'(irq), 0);
        check("per_ack_ovf", 32'(ovf), 0);

        // One-shot P=2, S=2
        configure(2, 2, 1'b0);
        start_run();
        wait_to(3);
        check("os_c3_value", 32'(value), 0);
        wait_to(4);
        check("os_c4_value", 32'(value), 1);
        wait_to(9);
        check("os_c9_tc",    32'(tc),    0);
        check("os_c9_value", 32'(value), 2);
        wait_to(10);
        check("os_c10_tc",      32'(tc),      1);
        check("os_c10_done",    32'(done),    1);
        check("os_c10_running", 32'(running), 0);
        check("os_c10_value",   32'(value),   2);
        check("os_c10_ovf",     32'(ovf),     0);
        wait_to(12);
        check("os_c12_tc",    32'(tc),    0);
        check("os_c12_value", 32'(value), 2);
        start_run();
        check("os_restart_running", 32'(running), 1);
        check("os_restart_value",   32'(value),   0);
        abort_run();
        ack();

        // Pause / resume / abort, P=10, S=0 periodic
        configure(10, 0, 1'b1);
        start_run();
        wait_to(6);
        check("pz_c6_value", 32'(value), 5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("pz_c7_running", 32'(running), 0);
        check("pz_c7_value",   32'(value),   5);
        wait_to(10);
        check("pz_c10_value", 32'(value), 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("pz_c11_running", 32'(running), 1);
        check("pz_c11_value",   32'(value),   5);
        wait_to(16);
        check("pz_c16_value", 32'(value), 10);
        check("pz_c16_tc",    32'(tc),    0);
        wait_to(17);
        check("pz_c17_tc", 32'(tc), 1);
        wait_to(19);
        check("pz_c19_value", 32'(value), 2);
        stop = 1'b1;
        tick();
        check("pz_c20_value",   32'(value),   2);
        check("pz_c20_running", 32'(running), 0);
        tick();
        stop = 1'b0;
        check("pz_c21_value", 32'(value), 0);
        check("pz_c21_done",  32'(done),  0);
        ack();

        // IRQ handshake and overrun, P=1, S=0 periodic
        configure(1, 0, 1'b1);
        start_run();
        wait_to(3);
        check("irq_c3_tc",  32'(tc),  1);
        check("irq_c3_irq", 32'(irq), 1);
        check("irq_c3_ovf", 32'(ovf), 0);
        wait_to(5);
        check("irq_c5_ovf", 32'(ovf), 1);
        wait_to(6);
        irq_ack = 1'b1;
        tick();
        check("irq_c7_tc",  32'(tc),  1);
        check("irq_c7_irq", 32'(irq), 1);
        check("irq_c7_ovf", 32'(ovf), 1);
        tick();
        irq_ack = 1'b0;
        check("irq_c8_irq", 32'(irq), 0);
        check("irq_c8_ovf", 32'(ovf), 0);
        tick();
        check("irq_c9_irq", 32'(irq), 1);
        check("irq_c9_ovf", 32'(ovf), 0);
        abort_run();
        ack();

        // Config rejection while running, P=3 periodic
        configure(3, 0, 1'b1);
        start_run();
        wait_to(2);
        cfg_period = 8'd0;
        cfg_we     = 1'b1;
        tick();
        cfg_we     = 1'b0;
        check("rej_c3_cfg_err", 32'(cfg_err), 1);
        tick();
        check("rej_c4_cfg_err", 32'(cfg_err), 0);
        wait_to(5);
        check("rej_c5_tc", 32'(tc), 1);
        abort_run();
        ack();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("prio_running", 32'(running), 0);
        check("prio_value",   32'(value),   0);

        // P=0 boundary, S=1 periodic: every tick is terminal
        configure(0, 1, 1'b1);
        start_run();
        wait_to(3);
        check("p0_c3_tc",    32'(tc),    1);
        check("p0_c3_value", 32'(value), 0);
        wait_to(4);
        check("p0_c4_tc", 32'(tc), 0);
        wait_to(5);
        check("p0_c5_tc", 32'(tc), 1);
        abort_run();
        ack();

        // Reset mid-operation, then default config (P=255, one-shot)
        configure(10, 0, 1'b1);
        start_run();
        wait_to(12);
        check("rm_c12_irq", 32'(irq), 1);
        wait_to(19);
        check("rm_c19_value", 32'(value), 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_value",   32'(value),   0);
        check("rm_irq",     32'(irq),     0);
        check("rm_running", 32'(running), 0);
        start_run();
        wait_to(256);
        check("def_c256_value", 32'(value), 255);
        check("def_c256_tc",    32'(tc),    0);
        wait_to(257);
        check("def_c257_tc",    32'(tc),    1);
        check("def_c257_done",  32'(done),  1);
        check("def_c257_value", 32'(value), 255);
        abort_run();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
